data_mem_sync: RTL

- Clocked, parametrised single-port data memory. It is the successor to the combinational testbench memory model.
- Adds configurable data width, depth and read latency, plus a req/ready/ack handshake, an out-of-range error flag, and a hardware clear sequencer on reset.
- Sits behind the MEM stage / bus interface in simulation and provides byte-granular writes for SB/SH/SW.

---
 rtl/data_mem_sync_pkg.sv | 28 ++
 rtl/data_mem_sync_byte_merge.sv | 18 +
 rtl/data_mem_sync.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/data_mem_sync_pkg.sv
// Shared types and helpers for the clocked data memory: state encodings,
// byte/offset geometry and byte-address to word-index conversion.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned offset_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(32);
  localparam int unsigned OFFSET_BITS    = offset_bits(32);

  // Byte offset bits are dropped; alignment is the caller's concern.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input int unsigned offset_w);
    return addr >> offset_w;
  endfunction

endpackage

// File: rtl/data_mem_sync_byte_merge.sv
// Byte-lane merge: take new bytes where sel is set, keep old bytes elsewhere.
module mem_byte_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int k = 0; k < DATA_WIDTH / 8; k++) begin
      if (sel_i[k]) merged_o[8*k +: 8] = new_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_mem_sync.sv
// Clocked single-port data memory with req/ready/ack handshake, byte writes,
// configurable read latency, range error flag and a zeroing pass after reset.
module data_mem_sync
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] byte_sel_i,
  output logic                    ready_o,
  output logic                    ack_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int unsigned OB = offset_bits(DATA_WIDTH);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a request is taken at a rising edge where req_i && ready_o;
  // ack_o pulses for exactly one cycle per accepted request, with err_o and
  // data_o qualified by it and forced to zero otherwise.

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [IW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [1:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_err_q, rd_err_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [63:0]           word_idx;
  logic                  in_range;
  logic [IW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  accept;
  logic                  mem_we;
  logic [IW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign word_idx = word_index(64'(addr_i), OB);
  assign in_range = word_idx < 64'(DEPTH);
  assign mem_idx  = word_idx[IW-1:0];
  assign old_word = mem[mem_idx];
  assign rd_word  = in_range ? old_word : '0;
  assign accept   = req_i && ready_o;

  mem_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (old_word),
    .new_i    (data_i),
    .sel_i    (byte_sel_i),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wait_d    = wait_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    data_d    = '0;
    mem_we    = 1'b0;
    mem_waddr = mem_idx;
    mem_wdata = merged_word;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept && we_i) begin
          mem_we = in_range && (|byte_sel_i);
          ack_d  = 1'b1;
          err_d  = !in_range;
        end else if (accept) begin
          rd_data_d = rd_word;
          rd_err_d  = !in_range;
          // Single-cycle reads never enter WAIT so ready_o stays high.
          if (LATENCY == 1) begin
            ack_d  = 1'b1;
            err_d  = !in_range;
            data_d = rd_word;
          end else begin
            state_d = ST_WAIT;
            wait_d  = 2'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == 2'd1) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          err_d   = rd_err_q;
          data_d  = rd_data_q;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      wait_q    <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wait_q    <= wait_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Outputs are gated by rst so they read as reset values in the reset cycle.
  assign ready_o = !rst && (state_q == ST_IDLE);
  assign busy_o  = rst ? CLEAR_ON_RESET : (state_q == ST_CLEAR);
  assign ack_o   = ack_q && !rst;
  assign err_o   = ack_o && err_q;
  assign data_o  = ack_o ? data_q : '0;

endmodule
